// File: rtl/main_fsm.sv
// Multicycle control sequencer for the shared ARM datapath. This is a Moore FSM with a
// memory-ready handshake. A bounded wait counter sends the FSM into a sticky FAULT state
// when memory does not respond in time.
module main_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       Branch,
    output logic       RegW,
    output logic       MemW,
    output logic       Fault,
    output logic [3:0] State
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StFault    = 4'd10
    } state_e;

    state_e          state_q, state_d;
    state_e          dec_state;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_wait;

    // Only I (bit 5) and L (bit 0) steer the sequence; the rest belong to the ALU decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A memory state that is still waiting either counts or times out.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        mem_wait = 1'b0;
        case (state_q)
            StFetch: begin
                if (MemReady) state_d = StDecode;
                else          mem_wait = 1'b1;
            end
            StDecode: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFault;
                endcase
            end
            StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
            StMemRead: begin
                if (MemReady) state_d = StMemWb;
                else          mem_wait = 1'b1;
            end
            StMemWrite: begin
                if (MemReady) state_d = StFetch;
                else          mem_wait = 1'b1;
            end
            StMemWb:    state_d = StFetch;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StFault:    state_d = StFault;
            default:    state_d = StFault;
        endcase
        // A MemReady in the limit cycle never reaches this branch, so it wins over the timeout.
        if (mem_wait) begin
            if (cnt_q == TimeoutVal) begin
                state_d = StFault;
            end else begin
                // Saturates at TimeoutVal, so it cannot wrap.
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // While reset is held, outputs show the FETCH decode so that a stale write request cannot leak.
    assign dec_state = reset ? StFetch : state_q;

    // Moore output decode. IRWrite and NextPC also follow MemReady, but only in FETCH.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        Branch    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Fault     = 1'b0;
        case (dec_state)
            StFetch: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            StMemWrite: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            StExecR: begin
                ALUOp = 1'b1;
            end
            StExecI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            StAluWb: begin
                RegW = 1'b1;
            end
            StBranch: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            StFault: begin
                Fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed vector table, hand-written timeout sequences,
// and randomized stimulus compared against an instruction-level reference model.
module tb_main_fsm;

    localparam int unsigned T = 15;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, Branch, RegW, MemW, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    main_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .MemReady (MemReady),
        .IRWrite  (IRWrite),
        .AdrSrc   (AdrSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ResultSrc(ResultSrc),
        .ALUOp    (ALUOp),
        .NextPC   (NextPC),
        .Branch   (Branch),
        .RegW     (RegW),
        .MemW     (MemW),
        .Fault    (Fault),
        .State    (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       irw;
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic       aluop;
        logic       npc;
        logic       br;
        logic       regw;
        logic       memw;
        logic       flt;
        logic [3:0] st;
    } out_t;

    typedef struct {
        bit       rst;
        bit [1:0] op;
        bit [5:0] fn;
        bit       mr;
        int       st;
        bit       regw;
        bit       memw;
        bit       npc;
        bit       aluop;
        bit       br;
        bit       flt;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int m_state = 0;  // state code as numbered in the state list
    int m_cnt   = 0;  // consecutive not-ready cycles spent in the current memory state

    // Expected outputs, taken from the per-state output list.
    function automatic out_t model_out(input int st, input bit mr, input bit rst);
        out_t o;
        int   d;
        o = '0;
        d = rst ? 0 : st;
        case (d)
            0:  begin o.a = 2'b01; o.b = 2'b10; o.rs = 2'b10; o.irw = mr; o.npc = mr; end
            1:  begin o.a = 2'b01; o.b = 2'b10; o.rs = 2'b10; end
            2:  begin o.b = 2'b01; end
            3:  begin o.adr = 1'b1; end
            4:  begin o.rs = 2'b01; o.regw = 1'b1; end
            5:  begin o.adr = 1'b1; o.memw = 1'b1; end
            6:  begin o.aluop = 1'b1; end
            7:  begin o.b = 2'b01; o.aluop = 1'b1; end
            8:  begin o.regw = 1'b1; end
            9:  begin o.a = 2'b10; o.b = 2'b01; o.rs = 2'b10; o.br = 1'b1; end
            10: begin o.flt = 1'b1; end
            default: ;
        endcase
        o.st = st[3:0];
        return o;
    endfunction

    // Advance the model across one rising edge.
    task automatic model_step(input bit rst, input bit [1:0] op, input bit [5:0] fn,
                              input bit mr);
        int  nx;
        bit  mem;
        case (m_state)
            0:       nx = mr ? 1 : 0;
            1:       nx = (op == 2'd1) ? 2 : (op == 2'd0) ? (fn[5] ? 7 : 6) : (op == 2'd2) ? 9 : 10;
            2:       nx = fn[0] ? 3 : 5;
            3:       nx = mr ? 4 : 3;
            5:       nx = mr ? 0 : 5;
            4, 8, 9: nx = 0;
            6, 7:    nx = 8;
            default: nx = 10;
        endcase
        mem = (m_state == 0) || (m_state == 3) || (m_state == 5);
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (mem && !mr) begin
            if (m_cnt == int'(T)) begin
                m_state = 10;
                m_cnt   = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_state = nx;
            m_cnt   = 0;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs to the model, then step the model.
    task automatic cyc(input bit rst, input bit [1:0] op, input bit [5:0] fn, input bit mr);
        out_t got, exp;
        @(negedge clk);
        reset    = rst;
        Op       = op;
        Funct    = fn;
        MemReady = mr;
        #1;
        exp = model_out(m_state, mr, rst);
        got = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, Branch, RegW,
               MemW, Fault, State};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got, exp);
        end
        model_step(rst, op, fn, mr);
    endtask

    vec_t vq[$];

    initial begin
        // rst op fn mr | st regw memw npc aluop br flt
        // DP register form: FETCH, DECODE, EXECUTER, ALUWB
        vq.push_back('{0, 2'd0, 6'h00, 1, 0, 0, 0, 1, 0, 0, 0});
        vq.push_back('{0, 2'd0, 6'h00, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd0, 6'h00, 1, 6, 0, 0, 0, 1, 0, 0});
        vq.push_back('{0, 2'd0, 6'h00, 1, 8, 1, 0, 0, 0, 0, 0});
        // LDR
        vq.push_back('{0, 2'd1, 6'h01, 1, 0, 0, 0, 1, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h01, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h01, 1, 2, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h01, 1, 3, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h01, 1, 4, 1, 0, 0, 0, 0, 0});
        // STR with a one-cycle fetch stall and three MEMWRITE wait cycles
        vq.push_back('{0, 2'd1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h00, 1, 0, 0, 0, 1, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h00, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h00, 1, 2, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h00, 0, 5, 0, 1, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h00, 0, 5, 0, 1, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h00, 0, 5, 0, 1, 0, 0, 0, 0});
        vq.push_back('{0, 2'd1, 6'h00, 1, 5, 0, 1, 0, 0, 0, 0});
        // Branch
        vq.push_back('{0, 2'd2, 6'h00, 1, 0, 0, 0, 1, 0, 0, 0});
        vq.push_back('{0, 2'd2, 6'h00, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd2, 6'h00, 1, 9, 0, 0, 0, 0, 1, 0});
        // DP immediate form, with reset asserted in EXECUTEI
        vq.push_back('{0, 2'd0, 6'h20, 1, 0, 0, 0, 1, 0, 0, 0});
        vq.push_back('{0, 2'd0, 6'h20, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 2'd0, 6'h20, 1, 7, 0, 0, 1, 0, 0, 0});
        vq.push_back('{0, 2'd0, 6'h20, 1, 0, 0, 0, 1, 0, 0, 0});
        // Undefined Op leads to FAULT; a single reset cycle clears it
        vq.push_back('{0, 2'd3, 6'h00, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd3, 6'h00, 1, 10, 0, 0, 0, 0, 0, 1});
        vq.push_back('{0, 2'd3, 6'h00, 1, 10, 0, 0, 0, 0, 0, 1});
        vq.push_back('{1, 2'd3, 6'h00, 0, 10, 0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 2'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0});
    end

    initial begin
        reset    = 1'b1;
        Op       = 2'd0;
        Funct    = 6'd0;
        MemReady = 1'b0;
        repeat (2) @(posedge clk);
        m_state = 0;
        m_cnt   = 0;

        // Reset state
        cyc(1'b1, 2'd0, 6'd0, 1'b0);
        chk("reset_state", int'(State), 0);
        chk("reset_fault", int'(Fault), 0);
        chk("reset_alusrca", int'(ALUSrcA), 1);

        // Directed table
        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].op, vq[i].fn, vq[i].mr);
            chk("tbl_state", int'(State), vq[i].st);
            chk("tbl_regw", int'(RegW), int'(vq[i].regw));
            chk("tbl_memw", int'(MemW), int'(vq[i].memw));
            chk("tbl_nextpc", int'(NextPC), int'(vq[i].npc));
            chk("tbl_aluop", int'(ALUOp), int'(vq[i].aluop));
            chk("tbl_branch", int'(Branch), int'(vq[i].br));
            chk("tbl_fault", int'(Fault), int'(vq[i].flt));
        end

        // Fetch timeout: T+1 cycles in FETCH, then sticky FAULT
        cyc(1'b1, 2'd0, 6'd0, 1'b0);
        for (int i = 0; i <= int'(T); i++) begin
            cyc(1'b0, 2'd0, 6'd0, 1'b0);
            chk("to_fetch_state", int'(State), 0);
            chk("to_nextpc", int'(NextPC), 0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'd0, 6'd0, 1'b1);
            chk("to_fault_state", int'(State), 10);
            chk("to_fault_sticky", int'(Fault), 1);
            chk("to_fault_nextpc", int'(NextPC), 0);
        end
        cyc(1'b1, 2'd0, 6'd0, 1'b0);
        cyc(1'b0, 2'd0, 6'd0, 1'b0);
        chk("to_reset_state", int'(State), 0);
        chk("to_reset_fault", int'(Fault), 0);

        // MemReady arriving exactly at the limit wins over the timeout
        cyc(1'b1, 2'd0, 6'd0, 1'b0);
        for (int i = 0; i < int'(T); i++) cyc(1'b0, 2'd0, 6'd0, 1'b0);
        cyc(1'b0, 2'd0, 6'd0, 1'b1);
        chk("edge_nextpc", int'(NextPC), 1);
        cyc(1'b0, 2'd0, 6'd0, 1'b1);
        chk("edge_decode", int'(State), 1);
        chk("edge_nofault", int'(Fault), 0);

        // Randomized run, alternating between responsive and sluggish memory phases
        cyc(1'b1, 2'd0, 6'd0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            bit       slow;
            bit [1:0] op;
            bit       mr;
            bit       rst;
            slow = ((i / 60) % 3) == 2;
            op   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            mr   = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 39) == 0);
            cyc(rst, op, 6'($urandom), mr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
